// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - opcode constants for loads, stores and NOP
//   - controller state encoding
//   - is_load() helper, shared with the forwarding unit
package pipe_ctrl_pkg;

   localparam logic [5:0] OP_NOP = 6'd0;
   localparam logic [5:0] OP_LB  = 6'd12;
   localparam logic [5:0] OP_LH  = 6'd13;
   localparam logic [5:0] OP_LW  = 6'd14;
   localparam logic [5:0] OP_SB  = 6'd15;
   localparam logic [5:0] OP_SH  = 6'd16;
   localparam logic [5:0] OP_SW  = 6'd17;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      STALL    = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus between the pipeline datapath and pipe_hazard_ctrl.
//   master : datapath side (drives hazard inputs, receives stage controls)
//   slave  : controller side
// Signals:
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 : ID-stage source registers and their use flags
//   ex_opcode, ex_rd, ex_we              : EX-stage instruction summary
//   br_taken                             : branch resolved taken in EX
//   mem_req, mem_ready                   : MEM-stage access handshake
//   pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en : stage controls
//   mem_err                              : sticky memory-timeout flag
// With PIPE_HAZARD_PERF_EN defined, also carries stall_cycles, flush_count and
// mem_wait_cycles performance counters.
interface pipe_hazard_ctrl_if;

   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_use_rs1;
   logic       id_use_rs2;
   logic [5:0] ex_opcode;
   logic [4:0] ex_rd;
   logic       ex_we;
   logic       br_taken;
   logic       mem_req;
   logic       mem_ready;

   logic       pc_en;
   logic       if_id_en;
   logic       if_id_flush;
   logic       id_ex_en;
   logic       id_ex_bubble;
   logic       ex_mem_en;
   logic       mem_err;

`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
   logic [31:0] mem_wait_cycles;
`endif

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
      output ex_opcode, ex_rd, ex_we, br_taken, mem_req, mem_ready,
      input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_err
`ifdef PIPE_HAZARD_PERF_EN
      , input stall_cycles, flush_count, mem_wait_cycles
`endif
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
      input  ex_opcode, ex_rd, ex_we, br_taken, mem_req, mem_ready,
      output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_err
`ifdef PIPE_HAZARD_PERF_EN
      , output stall_cycles, flush_count, mem_wait_cycles
`endif
   );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect: purely combinational load-use hazard detection between the
// instruction in EX and the instruction in ID.
// Ports:
//   ex_opcode_i, ex_rd_i, ex_we_i          : EX instruction
//   id_rs1_i, id_rs2_i                     : ID source registers
//   id_use_rs1_i, id_use_rs2_i             : ID actually reads that source
//   lu_o                                   : hazard present
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [5:0] ex_opcode_i,
   input  logic [4:0] ex_rd_i,
   input  logic       ex_we_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_use_rs1_i,
   input  logic       id_use_rs2_i,
   output logic       lu_o
);

   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
      rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);
      // x0 is hardwired, so a load targeting it never produces a hazard
      lu_o    = is_load(ex_opcode_i) && ex_we_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Handles load-use bubbles, taken-branch squashes and multi-cycle data-memory
// waits (with a timeout that raises a sticky mem_err and forces release).
// Ports:
//   clk    : pipeline clock
//   rst_n  : asynchronous active-low reset; forces the stage controls to their
//            safe values (enables 0, flush/bubble 1) while low
//   bus    : pipe_hazard_ctrl_if.slave carrying hazard inputs and stage controls
// Parameters:
//   LOAD_USE_STALLS : bubbles per load-use hazard (1..3)
//   MEM_TIMEOUT     : max consecutive memory-wait cycles before abort (1..255)
// Optional: define PIPE_HAZARD_PERF_EN to add stall_cycles, flush_count and
// mem_wait_cycles counters to the bus.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned LOAD_USE_STALLS = 1,
   parameter int unsigned MEM_TIMEOUT     = 15
) (
   input logic               clk,
   input logic               rst_n,
   pipe_hazard_ctrl_if.slave bus
);

   localparam logic [1:0] StallInit  = 2'(LOAD_USE_STALLS - 1);
   localparam logic [7:0] TimeoutMax = 8'(MEM_TIMEOUT);
   localparam logic       MultiStall = (LOAD_USE_STALLS > 1);

   state_e     state_q, state_d;
   logic [1:0] stall_cnt_q, stall_cnt_d;
   logic [7:0] timeout_q, timeout_d;
   logic       mem_err_q, mem_err_d;

   logic lu;
   logic mem_stall;
   logic decide;    // evaluate branch / load-use rules this cycle
   logic br_fire;   // taken-branch squash applied
   logic mem_frz;   // pipeline frozen by the memory access

   logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_en_c, id_ex_bubble_c, ex_mem_en_c;

   load_use_detect u_load_use_detect (
      .ex_opcode_i  (bus.ex_opcode),
      .ex_rd_i      (bus.ex_rd),
      .ex_we_i      (bus.ex_we),
      .id_rs1_i     (bus.id_rs1),
      .id_rs2_i     (bus.id_rs2),
      .id_use_rs1_i (bus.id_use_rs1),
      .id_use_rs2_i (bus.id_use_rs2),
      .lu_o         (lu)
   );

   always_comb begin
      state_d        = state_q;
      stall_cnt_d    = stall_cnt_q;
      timeout_d      = timeout_q;
      mem_err_d      = mem_err_q;
      pc_en_c        = 1'b0;
      if_id_en_c     = 1'b0;
      if_id_flush_c  = 1'b0;
      id_ex_en_c     = 1'b0;
      id_ex_bubble_c = 1'b0;
      ex_mem_en_c    = 1'b0;
      decide         = 1'b0;
      br_fire        = 1'b0;
      mem_frz        = 1'b0;
      mem_stall      = bus.mem_req && !bus.mem_ready;

      unique case (state_q)
         RUN: begin
            if (mem_stall) begin
               mem_frz   = 1'b1;
               state_d   = MEM_WAIT;
               timeout_d = 8'd1;
            end else begin
               decide = 1'b1;
            end
         end
         STALL: begin
            if (mem_stall) begin
               // Whole pipe frozen; the remaining bubble count is preserved
               mem_frz = 1'b1;
            end else begin
               id_ex_en_c     = 1'b1;
               id_ex_bubble_c = 1'b1;
               ex_mem_en_c    = 1'b1;
               stall_cnt_d    = stall_cnt_q - 2'd1;
               if (stall_cnt_q <= 2'd1) begin
                  state_d = RUN;
               end
            end
         end
         MEM_WAIT: begin
            if (bus.mem_ready || (timeout_q >= TimeoutMax)) begin
               // Release cycle: normal RUN decisions apply, memory rule skipped
               decide    = 1'b1;
               timeout_d = 8'd0;
               if (!bus.mem_ready) begin
                  mem_err_d = 1'b1;
               end
            end else begin
               mem_frz   = 1'b1;
               timeout_d = timeout_q + 8'd1;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase

      if (decide) begin
         state_d = RUN;
         if (bus.br_taken) begin
            // ID instruction is wrong-path, so any load-use on it is moot
            br_fire        = 1'b1;
            pc_en_c        = 1'b1;
            if_id_en_c     = 1'b1;
            if_id_flush_c  = 1'b1;
            id_ex_en_c     = 1'b1;
            id_ex_bubble_c = 1'b1;
            ex_mem_en_c    = 1'b1;
         end else if (lu) begin
            id_ex_en_c     = 1'b1;
            id_ex_bubble_c = 1'b1;
            ex_mem_en_c    = 1'b1;
            if (MultiStall) begin
               state_d     = STALL;
               stall_cnt_d = StallInit;
            end
         end else begin
            pc_en_c     = 1'b1;
            if_id_en_c  = 1'b1;
            id_ex_en_c  = 1'b1;
            ex_mem_en_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         stall_cnt_q <= 2'd0;
         timeout_q   <= 8'd0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
         mem_err_q   <= mem_err_d;
      end
   end

   // Reset overrides the decoded controls so the pipe holds NOPs while in reset
   assign bus.pc_en        = rst_n & pc_en_c;
   assign bus.if_id_en     = rst_n & if_id_en_c;
   assign bus.id_ex_en     = rst_n & id_ex_en_c;
   assign bus.ex_mem_en    = rst_n & ex_mem_en_c;
   assign bus.if_id_flush  = ~rst_n | if_id_flush_c;
   assign bus.id_ex_bubble = ~rst_n | id_ex_bubble_c;
   assign bus.mem_err      = mem_err_q;

`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;
   logic [31:0] mem_wait_cycles_q, mem_wait_cycles_d;

   always_comb begin
      stall_cycles_d    = stall_cycles_q;
      flush_count_d     = flush_count_q;
      mem_wait_cycles_d = mem_wait_cycles_q;
      if (!pc_en_c) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (br_fire) begin
         flush_count_d = flush_count_q + 32'd1;
      end
      if (mem_frz) begin
         mem_wait_cycles_d = mem_wait_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q    <= 32'd0;
         flush_count_q     <= 32'd0;
         mem_wait_cycles_q <= 32'd0;
      end else begin
         stall_cycles_q    <= stall_cycles_d;
         flush_count_q     <= flush_count_d;
         mem_wait_cycles_q <= mem_wait_cycles_d;
      end
   end

   assign bus.stall_cycles    = stall_cycles_q;
   assign bus.flush_count     = flush_count_q;
   assign bus.mem_wait_cycles = mem_wait_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. Two instances share stimulus:
//   A : LOAD_USE_STALLS=1, B : LOAD_USE_STALLS=2 (both MEM_TIMEOUT=15).
// Each stimulus cycle pushes hand-computed expected controls for both; a monitor
// pops on every falling edge and compares.
// Vector bit order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_err}
module tb_pipe_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   localparam logic [6:0] R    = 7'b0010100;  // in reset
   localparam logic [6:0] N    = 7'b1101010;  // normal flow
   localparam logic [6:0] LU   = 7'b0000110;  // load-use bubble
   localparam logic [6:0] BR   = 7'b1010110;  // taken branch
   localparam logic [6:0] W    = 7'b0000000;  // memory freeze
   localparam logic [6:0] NE   = 7'b1101011;  // normal flow, mem_err set
   localparam logic [6:0] WE   = 7'b0000001;  // memory freeze, mem_err set
   localparam logic [6:0] ALL  = 7'b1111111;
   localparam logic [6:0] MLU  = 7'b1110111;  // id_ex_en not checked
   localparam logic [6:0] MBR  = 7'b1010111;  // if_id_en, id_ex_en not checked
   localparam logic [6:0] MFRZ = 7'b1101011;  // flush/bubble not checked

   typedef struct {
      string      nm;
      logic [6:0] ea;
      logic [6:0] ca;
      logic [6:0] eb;
      logic [6:0] cb;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_we, br_taken, mem_req, mem_ready;
   logic [5:0] ex_opcode;

   exp_t sb_q[$];
   exp_t cur;
   int   checks;
   int   errors;

   pipe_hazard_ctrl_if bus_a ();
   pipe_hazard_ctrl_if bus_b ();

   assign bus_a.id_rs1 = id_rs1;         assign bus_b.id_rs1 = id_rs1;
   assign bus_a.id_rs2 = id_rs2;         assign bus_b.id_rs2 = id_rs2;
   assign bus_a.id_use_rs1 = id_use_rs1; assign bus_b.id_use_rs1 = id_use_rs1;
   assign bus_a.id_use_rs2 = id_use_rs2; assign bus_b.id_use_rs2 = id_use_rs2;
   assign bus_a.ex_opcode = ex_opcode;   assign bus_b.ex_opcode = ex_opcode;
   assign bus_a.ex_rd = ex_rd;           assign bus_b.ex_rd = ex_rd;
   assign bus_a.ex_we = ex_we;           assign bus_b.ex_we = ex_we;
   assign bus_a.br_taken = br_taken;     assign bus_b.br_taken = br_taken;
   assign bus_a.mem_req = mem_req;       assign bus_b.mem_req = mem_req;
   assign bus_a.mem_ready = mem_ready;   assign bus_b.mem_ready = mem_ready;

   pipe_hazard_ctrl #(.LOAD_USE_STALLS(1), .MEM_TIMEOUT(15)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   pipe_hazard_ctrl #(.LOAD_USE_STALLS(2), .MEM_TIMEOUT(15)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] act_of_a();
      return {bus_a.pc_en, bus_a.if_id_en, bus_a.if_id_flush, bus_a.id_ex_en,
              bus_a.id_ex_bubble, bus_a.ex_mem_en, bus_a.mem_err};
   endfunction

   function automatic logic [6:0] act_of_b();
      return {bus_b.pc_en, bus_b.if_id_en, bus_b.if_id_flush, bus_b.id_ex_en,
              bus_b.id_ex_bubble, bus_b.ex_mem_en, bus_b.mem_err};
   endfunction

   task automatic cmp(input string nm, input string d, input logic [6:0] act,
                      input logic [6:0] exp, input logic [6:0] care);
      checks++;
      if (((act ^ exp) & care) !== 7'd0) begin
         errors++;
         $display("FAIL %s dut=%s got=%b want=%b care=%b", nm, d, act, exp, care);
      end
   endtask

   // Monitor: controls are combinational, so every cycle is an output cycle
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         cur = sb_q.pop_front();
         cmp(cur.nm, "A", act_of_a(), cur.ea, cur.ca);
         cmp(cur.nm, "B", act_of_b(), cur.eb, cur.cb);
      end
   end

   task automatic set_in(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [5:0] op, input logic [4:0] rd,
                         input logic we, input logic br, input logic req, input logic rdy);
      id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
      ex_opcode = op; ex_rd = rd; ex_we = we; br_taken = br;
      mem_req = req; mem_ready = rdy;
   endtask

   task automatic chk(input string nm, input logic [6:0] ea, input logic [6:0] ca,
                      input logic [6:0] eb, input logic [6:0] cb);
      exp_t e;
      e.nm = nm; e.ea = ea; e.ca = ca; e.eb = eb; e.cb = cb;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      set_in(5'd0, 1'b0, 5'd0, 1'b0, OP_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog sim time limit reached checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle();
      @(posedge clk); #1;
      chk("reset", R, ALL, R, ALL);
      rst_n = 1'b1;
      chk("normal", N, ALL, N, ALL);

      // Load-use via rs1; B needs a second bubble
      set_in(5'd5, 1'b1, 5'd0, 1'b0, OP_LW, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu_rs1", LU, MLU, LU, MLU);
      set_in(5'd5, 1'b1, 5'd0, 1'b0, OP_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_after", N, ALL, LU, MLU);
      chk("lu_resume", N, ALL, N, ALL);

      // No-hazard boundaries
      set_in(5'd0, 1'b1, 5'd0, 1'b0, OP_LW, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("nh_rd0", N, ALL, N, ALL);
      set_in(5'd5, 1'b0, 5'd6, 1'b1, OP_LW, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("nh_rs2_mismatch", N, ALL, N, ALL);
      set_in(5'd5, 1'b1, 5'd0, 1'b0, OP_SW, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("nh_sw", N, ALL, N, ALL);
      set_in(5'd5, 1'b1, 5'd5, 1'b1, OP_SB, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("nh_sb", N, ALL, N, ALL);
      set_in(5'd7, 1'b1, 5'd0, 1'b0, OP_LH, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("nh_we0", N, ALL, N, ALL);

      // Load-use via rs2 on a byte load
      set_in(5'd0, 1'b0, 5'd9, 1'b1, OP_LB, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu_rs2", LU, MLU, LU, MLU);
      set_in(5'd0, 1'b0, 5'd9, 1'b1, OP_SH, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu_rs2_after", N, ALL, LU, MLU);

      // Branch wins over load-use
      set_in(5'd5, 1'b1, 5'd0, 1'b0, OP_LW, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("br_lu", BR, MBR, BR, MBR);
      idle();
      chk("br_after", N, ALL, N, ALL);

      // Memory wait: four frozen cycles, release on the fifth
      set_in(5'd0, 1'b0, 5'd0, 1'b0, OP_NOP, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) chk("mw_wait", W, ALL, W, ALL);
      mem_ready = 1'b1;
      chk("mw_release", N, ALL, N, ALL);
      idle();
      chk("mw_after", N, ALL, N, ALL);

      // Release cycle applies load-use
      mem_req = 1'b1;
      chk("mwlu_wait0", W, ALL, W, ALL);
      chk("mwlu_wait1", W, ALL, W, ALL);
      set_in(5'd3, 1'b1, 5'd0, 1'b0, OP_LW, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("mwlu_release", LU, MLU, LU, MLU);
      idle();
      chk("mwlu_after", N, ALL, LU, MLU);
      chk("mwlu_resume", N, ALL, N, ALL);

      // Memory freeze inside STALL holds B's count
      set_in(5'd4, 1'b1, 5'd0, 1'b0, OP_LW, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("frz_lu", LU, MLU, LU, MLU);
      set_in(5'd4, 1'b1, 5'd0, 1'b0, OP_NOP, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) chk("frz_hold", W, ALL, W, MFRZ);
      mem_ready = 1'b1;
      chk("frz_release", N, ALL, LU, MLU);
      idle();
      chk("frz_after", N, ALL, N, ALL);

      // Timeout: 15 wait cycles then forced release, mem_err sticky
      mem_req = 1'b1;
      for (int i = 0; i < 15; i++) chk("tmo_wait", W, ALL, W, ALL);
      chk("tmo_release", N, ALL, N, ALL);
      mem_req = 1'b0;
      chk("tmo_err_set", NE, ALL, NE, ALL);
      chk("tmo_err_sticky", NE, ALL, NE, ALL);

      // Reset in the middle of a memory wait
      mem_req = 1'b1;
      chk("rst_wait0", WE, ALL, WE, ALL);
      chk("rst_wait1", WE, ALL, WE, ALL);
      rst_n = 1'b0;
      chk("rst_mid", R, ALL, R, ALL);
      rst_n = 1'b1;
      mem_req = 1'b0;
      chk("rst_after", N, ALL, N, ALL);

      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards between ID and EX, squashes wrong-path instructions on a taken branch resolved in EX, and freezes the pipeline while a multi-cycle data-memory access is outstanding.
- Drives the enables and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.

Parameters:
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (1 with MEM->EX forwarding, 2 without); legal 1..3.
- MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before abort; legal 1..255.

Ports:
- clk, input, 1, pipeline clock.
- rst_n, input, 1, asynchronous active-low reset.
- id_rs1 / id_rs2, input, 5 each, source registers of the instruction in ID.
- id_use_rs1 / id_use_rs2, input, 1 each, ID instruction actually reads that source.
- ex_opcode, input, 6, opcode held in ID/EX.
- ex_rd, input, 5, destination register of the EX instruction.
- ex_we, input, 1, ctrl_we of the EX instruction.
- br_taken, input, 1, branch/jump in EX resolved taken this cycle.
- mem_req, input, 1, MEM stage has a data-memory access this cycle.
- mem_ready, input, 1, data memory completes the access this cycle.
- pc_en, output, 1, PC update enable.
- if_id_en, output, 1, IF/ID load enable.
- if_id_flush, output, 1, load NOP into IF/ID.
- id_ex_en, output, 1, ID/EX load enable.
- id_ex_bubble, output, 1, load NOP (opcode 0, ctrl_we 0) into ID/EX.
- ex_mem_en, output, 1, EX/MEM load enable.
- mem_err, output, 1, sticky memory-timeout flag.

Behaviour:
- State register: RUN, STALL, MEM_WAIT. Stall counter is 2 bits; timeout counter is 8 bits. All state is reset asynchronously.
- Outputs are combinational from state and inputs; the active clock edge is the one ending the cycle.
- While rst_n=0: pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_en=0, if_id_flush=1, id_ex_bubble=1, mem_err=0, state=RUN, counters=0.
- Load-use hazard (lu) is true when all of the following hold:
  - ex_opcode is in {OP_LB, OP_LH, OP_LW};
  - ex_we=1 and ex_rd!=0;
  - (id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd).
- Priority in RUN: memory wait > branch > load-use > normal.
- RUN:
  - mem_req and !mem_ready: all enables 0, no flush/bubble; go to MEM_WAIT with timeout=1.
  - br_taken: pc_en=1, if_id_flush=1, id_ex_bubble=1, ex_mem_en=1. lu is ignored because the ID instruction is squashed. Stay in RUN.
  - lu: pc_en=0, if_id_en=0, id_ex_bubble=1, ex_mem_en=1. If LOAD_USE_STALLS>1, go to STALL with count=LOAD_USE_STALLS-1; otherwise stay in RUN.
  - Otherwise: all enables 1, no flush/bubble.
- STALL:
  - pc_en=0, if_id_en=0, id_ex_bubble=1, ex_mem_en=1; decrement count; go to RUN when count reaches 0.
  - If mem_req and !mem_ready: all enables 0 and the count is frozen; remain in STALL.
  - br_taken cannot occur in STALL, because EX holds a bubble.
- MEM_WAIT:
  - All enables 0, no flush/bubble; timeout increments each cycle.
  - mem_ready=1: release cycle. Outputs follow the RUN rules (branch and lu are evaluated), then go to RUN (or STALL per lu). The timeout counter clears.
  - timeout==MEM_TIMEOUT without mem_ready: set mem_err=1 and force a release cycle as above.
- mem_err clears only on reset.
- The EX-stage store write-enable is not gated here; a bubbled ID/EX carries ctrl_we=0.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- With it: adds outputs stall_cycles[31:0] (cycles with pc_en=0 outside reset), flush_count[31:0] (taken-branch squashes) and mem_wait_cycles[31:0]. All three reset to 0 and wrap at 2^32.
- Without it: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode constants OP_LB=6'd12, OP_LH=6'd13, OP_LW=6'd14, OP_SB=6'd15, OP_SH=6'd16, OP_SW=6'd17;
  - the state enum {RUN, STALL, MEM_WAIT};
  - the NOP opcode 6'd0.
- Sub-module: load_use_detect (pure combinational lu computation), reusable by the forwarding unit.

Test Plan:
- Load-use: EX=LW rd=5 we=1, ID rs1=5 use_rs1=1, LOAD_USE_STALLS=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1; next cycle all enables 1.
- No hazard cases: ex_rd=0, or ID uses rs2 but rs2!=5, or ex_opcode=OP_SW -> no stall.
- Branch plus hazard together: br_taken=1 with lu=1 -> if_id_flush=1, id_ex_bubble=1, pc_en=1, no stall.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles then 1 -> all enables 0 for 4 cycles, release on the 5th; mem_err=0.
- Timeout: mem_ready held 0 with MEM_TIMEOUT=15 -> forced release after 15 wait cycles, mem_err=1 and sticky. rst_n asserted mid-MEM_WAIT -> outputs take reset values immediately; state is RUN after deassertion.
- Double stall: LOAD_USE_STALLS=2 -> two consecutive bubble cycles; mem_req=1, mem_ready=0 during STALL freezes the count for 3 cycles.
